// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier: FSM states,
// Booth digit control bundle, default operand width and the group decoder.
package booth_pkg;

  localparam int unsigned N_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Digit d in {-2,-1,0,+1,+2} as sign, doubling and zero flags
  typedef struct packed {
    logic neg;
    logic two;
    logic zero;
  } booth_ctrl_t;

  localparam booth_ctrl_t CTRL_ZERO = '{neg: 1'b0, two: 1'b0, zero: 1'b1};

  // Decode {b[2i+1], b[2i], b[2i-1]} into Booth digit controls
  function automatic booth_ctrl_t booth_decode(input logic [2:0] grp);
    booth_ctrl_t c;
    c.neg  = grp[2] & ~(grp[1] & grp[0]);
    c.two  = (grp == 3'b011) | (grp == 3'b100);
    c.zero = (grp == 3'b000) | (grp == 3'b111);
    return c;
  endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Booth digit encoder: turns one 3-bit multiplier group into digit controls
// and the sign-extended, position-shifted 2N-bit partial product d*a.
module booth_digit_enc
  import booth_pkg::*;
#(
  parameter int unsigned N  = N_DEFAULT,
  parameter int unsigned SW = 4
) (
  input  logic [2:0]     grp_i,
  input  logic [N-1:0]   a_i,
  input  logic [SW-1:0]  sh_i,
  output booth_ctrl_t    ctrl_o,
  output logic [2*N-1:0] pp_o
);

  logic [2*N-1:0] mag;

  // Scale, negate and position the multiplicand for this digit
  always_comb begin
    ctrl_o = booth_decode(grp_i);
    mag    = {{N{a_i[N-1]}}, a_i};
    if (ctrl_o.two) mag = mag << 1;
    if (ctrl_o.neg) mag = '0 - mag;
    pp_o   = ctrl_o.zero ? '0 : (mag << sh_i);
  end

endmodule

// File: rtl/booth_seq_mult_ctrl.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, product
// held with valid/ready handshake. Optional macro BOOTH_EARLY_TERM_EN stops
// as soon as every remaining Booth digit is zero.
module booth_seq_mult_ctrl
  import booth_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int unsigned P  = N / 2;
  localparam int unsigned CW = $clog2(P) + 1;

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, b_q;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q;

  logic [N:0]     bx;
  logic [2:0]     grp;
  booth_ctrl_t    ctrl;
  logic [2*N-1:0] pp;
  logic           last_digit;
  logic           rest_zero;
  logic           finish;

  // Select the current Booth group with b[-1] = 0 appended below bit 0
  always_comb begin
    bx  = {b_q, 1'b0};
    grp = 3'(bx >> {cnt_q, 1'b0});
  end

  booth_digit_enc #(
    .N  (N),
    .SW (CW + 1)
  ) u_enc (
    .grp_i  (grp),
    .a_i    (a_q),
    .sh_i   ({cnt_q, 1'b0}),
    .ctrl_o (ctrl),
    .pp_o   (pp)
  );

  // Remaining digits cnt+1..P-1 are all zero exactly when b[N-1:2cnt+1]
  // is a pure sign extension.
  always_comb begin
    last_digit = (cnt_q == CW'(P - 1));
    rest_zero  = ((b_q ^ {N{b_q[N-1]}}) >> {cnt_q, 1'b1}) == '0;
`ifdef BOOTH_EARLY_TERM_EN
    finish     = last_digit | rest_zero;
`else
    finish     = last_digit;
`endif
  end

  // Accumulate only for non-zero digits
  always_comb begin
    acc_d = acc_q;
    if (ctrl != CTRL_ZERO) acc_d = acc_q + pp;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (finish)    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) || (state_q == DONE);
    product   = acc_q;
  end

  // Operand capture, accumulator and digit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == IDLE && in_valid) begin
      a_q   <= a;
      b_q   <= b;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// Self-checking bench for booth_seq_mult_ctrl (N=16): directed vector table,
// hand-written stall/abort/priority sequences, and randomized traffic with
// back-pressure against an arithmetic reference model.
module tb_booth_seq_mult_ctrl;

  localparam int N  = 16;
  localparam int P  = N / 2;
  localparam int NR = 4000;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] product;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2*N-1:0] exp_q[$];

  typedef struct {
    string        name;
    logic [15:0]  a;
    logic [15:0]  b;
    logic [31:0]  prod;
  } vec_t;

  always #5 clk = ~clk;

  booth_seq_mult_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference product: plain signed arithmetic, truncated to 2N bits
  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p[31:0];
  endfunction

  // Reference latency (edges after accept until out_valid is seen)
  function automatic int ref_lat(input logic [15:0] bb);
    int h;
    int d;
    int bm1;
    h = 0;
    for (int i = 0; i < P; i++) begin
      bm1 = (i == 0) ? 0 : int'(bb[2*i-1]);
      d   = -2 * int'(bb[2*i+1]) + int'(bb[2*i]) + bm1;
      if (d != 0) h = i;
    end
`ifdef BOOTH_EARLY_TERM_EN
    return h + 1;
`else
    return (h >= 0) ? P : 0;
`endif
  endfunction

  // One full transaction from IDLE, checking latency, result and hand-back
  task automatic run_op(input string name, input logic [15:0] av, input logic [15:0] bv,
                        input logic [31:0] ep, input int el);
    int lat;
    a = av;
    b = bv;
    in_valid = 1'b1;
    check({name, " in_ready_before"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    check({name, " busy_after_accept"}, busy, 1);
    lat = 0;
    while (!out_valid && lat < 4 * P) begin
      tick();
      lat++;
    end
    check({name, " latency"}, lat, el);
    check({name, " product"}, product, ep);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " out_valid_after_take"}, out_valid, 0);
    check({name, " in_ready_after_take"}, in_ready, 1);
  endtask

  initial begin
    vec_t vt[10];
    logic [31:0] ep;
    int          lat;
    bit          seen;

    vt[0] = '{"3x5",          16'd3,      16'd5,      32'h0000000F};
    vt[1] = '{"min_x_min",    16'h8000,   16'h8000,   32'h40000000};
    vt[2] = '{"m1_x_max",     16'hFFFF,   16'h7FFF,   32'hFFFF8001};
    vt[3] = '{"7x1",          16'd7,      16'd1,      32'h00000007};
    vt[4] = '{"2x-3",         16'd2,      16'hFFFD,   32'hFFFFFFFA};
    vt[5] = '{"max_x_max",    16'h7FFF,   16'h7FFF,   32'h3FFF0001};
    vt[6] = '{"min_x_max",    16'h8000,   16'h7FFF,   32'hC0008000};
    vt[7] = '{"0x-5",         16'd0,      16'hFFFB,   32'h00000000};
    vt[8] = '{"-7x-9",        16'hFFF9,   16'hFFF7,   32'h0000003F};
    vt[9] = '{"1234x-1",      16'd1234,   16'hFFFF,   32'hFFFFFB2E};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 16'h1234;
    b = 16'h5678;
    tick();
    tick();
    rst = 1'b0;
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset product", product, 0);

    // Directed vectors
    for (int i = 0; i < 10; i++)
      run_op(vt[i].name, vt[i].a, vt[i].b, vt[i].prod, ref_lat(vt[i].b));

    // Consumer stalls for 5 cycles in DONE
    a = 16'hFFFB;
    b = 16'h1234;
    ep = ref_mul(16'hFFFB, 16'h1234);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4 * P) begin
      tick();
      lat++;
    end
    check("stall latency", lat, ref_lat(16'h1234));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall out_valid", out_valid, 1);
      check("stall product", product, ep);
      check("stall in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall release in_ready", in_ready, 1);
    check("stall release busy", busy, 0);

    // Reset abort at cnt=3, then a fresh operation
    a = 16'd100;
    b = 16'h3039;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort in_ready", in_ready, 1);
    check("abort busy", busy, 0);
    check("abort out_valid", out_valid, 0);
    check("abort product", product, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    check("abort no out_valid", seen, 0);
    run_op("after_abort", 16'd2, 16'hFFFD, 32'hFFFFFFFA, ref_lat(16'hFFFD));

    // Reset beats in_valid on the same edge
    a = 16'd9;
    b = 16'd9;
    in_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_prio busy", busy, 0);
    check("rst_prio in_ready", in_ready, 1);

    // Randomized traffic with back-pressure on both sides
    fork
      begin
        for (int i = 0; i < NR; i++) begin
          logic [15:0] av, bv;
          bit          took;
          int          t;
          repeat ($urandom_range(0, 2)) tick();
          av = 16'($urandom);
          bv = 16'($urandom);
          a = av;
          b = bv;
          in_valid = 1'b1;
          t = 0;
          do begin
            took = in_ready;
            tick();
            t++;
          end while (!took && t < 200);
          check("rand accept", took, 1);
          exp_q.push_back(ref_mul(av, bv));
          in_valid = 1'b0;
          a = 16'($urandom);
          b = 16'($urandom);
        end
      end
      begin
        int got;
        int t;
        got = 0;
        t = 0;
        while (got < NR && t < NR * 40) begin
          bit          fire;
          logic [31:0] pv;
          out_ready = ($urandom_range(0, 3) != 0);
          fire = out_valid & out_ready;
          pv = product;
          tick();
          t++;
          if (fire) begin
            if (exp_q.size() == 0) check("rand unexpected product", 1, 0);
            else                   check("rand product", pv, exp_q.pop_front());
            got++;
          end
        end
        out_ready = 1'b0;
        check("rand product count", got, NR);
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
